// File: rtl/poly_tone_synth.sv
// Multi-channel square-wave tone generator with per-channel attack/sustain/release
// envelope, stereo pan masks and saturating mix into signed 16-bit PCM.
module poly_tone_synth #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 22,
  parameter int VOL_W    = 3,
  parameter int ENV_MAX  = 15,
  parameter int ENV_TICK = 100000,
  parameter int AMP_UNIT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VOL_W-1:0]        volume,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  input  logic [NUM_CH-1:0]       ch_gate,
  input  logic [NUM_CH-1:0]       ch_pan_l,
  input  logic [NUM_CH-1:0]       ch_pan_r,
  output logic signed [15:0]      audio_left,
  output logic signed [15:0]      audio_right,
  output logic [NUM_CH-1:0]       ch_active
);

  localparam int PRE_W = (ENV_TICK > 1) ? $clog2(ENV_TICK) : 1;
  localparam int ENV_W = $clog2(ENV_MAX + 1);
  localparam int SUM_W = 16 + $clog2(NUM_CH) + 1;
  localparam logic signed [SUM_W-1:0] SAT_POS = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SAT_NEG = -SAT_POS;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

  logic [PRE_W-1:0]        presc;
  logic                    tick;
  logic signed [SUM_W-1:0] sample [NUM_CH];
  logic signed [SUM_W-1:0] sum_l;
  logic signed [SUM_W-1:0] sum_r;

  assign tick = (presc == PRE_W'(ENV_TICK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    env_state_t       state;
    logic [ENV_W-1:0] env;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             pol;
    logic             gate;
    logic             rest;
    logic [SUM_W-1:0] amp;

    assign div  = ch_div[i*DIV_W +: DIV_W];
    assign gate = ch_gate[i];
    assign rest = (div <= DIV_W'(1));

    // The >= compare lets a divider lowered below the running count wrap at once.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        pol <= 1'b0;
      end else if (cnt >= div) begin
        cnt <= '0;
        pol <= ~pol;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        env   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (gate) state <= ATTACK;
          end
          ATTACK: begin
            if (!gate) begin
              state <= RELEASE;
            end else if (env >= ENV_W'(ENV_MAX)) begin
              state <= SUSTAIN;
            end else if (tick) begin
              env <= env + ENV_W'(1);
              if (env + ENV_W'(1) == ENV_W'(ENV_MAX)) state <= SUSTAIN;
            end
          end
          SUSTAIN: begin
            if (!gate) state <= RELEASE;
          end
          RELEASE: begin
            if (gate) begin
              state <= ATTACK;
            end else if (env == '0) begin
              state <= IDLE;
            end else if (tick) begin
              env <= env - ENV_W'(1);
              if (env == ENV_W'(1)) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign ch_active[i] = (state != IDLE);
    assign amp = SUM_W'(volume) * SUM_W'(env) * SUM_W'(AMP_UNIT);
    assign sample[i] = (rest || env == '0) ? '0 : (pol ? $signed(amp) : -$signed(amp));
  end

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_pan_l[i]) sum_l = sum_l + sample[i];
      if (ch_pan_r[i]) sum_r = sum_r + sample[i];
    end
  end

  // Symmetric clamp: -32768 is never produced.
  function automatic logic signed [15:0] saturate(input logic signed [SUM_W-1:0] s);
    if (s > SAT_POS) begin
      return 16'sd32767;
    end else if (s < SAT_NEG) begin
      return -16'sd32767;
    end else begin
      return s[15:0];
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_left  <= '0;
      audio_right <= '0;
    end else begin
      audio_left  <= saturate(sum_l);
      audio_right <= saturate(sum_r);
    end
  end

endmodule
